// File: rtl/distance_pkg.sv
// distance_pkg: shared widths, window depth, filter state encoding and helpers
package distance_pkg;
    localparam int DIST_W    = 21;
    localparam int SUM_W     = 23;
    localparam int WIN_DEPTH = 4;

    typedef enum logic [1:0] {ST_FILL, ST_TRACK, ST_SUSPECT} state_t;

    // Unsigned magnitude of a - b; never wraps.
    function automatic logic [DIST_W-1:0] abs_diff(input logic [DIST_W-1:0] a, input logic [DIST_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/dist_window.sv
// dist_window: 4-deep sample window with running sum
//   clk, rst_n        clock, async active-low reset
//   load_one          shift din in, drop oldest, sum += din - oldest
//   load_all          flush and fill every slot with din, sum = 4*din
//   clear             empty the window
//   din               sample to load
//   next_sum          sum after a load_one of din (combinational)
//   fill              samples held, 0..4
module dist_window
    import distance_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_one,
    input  logic              load_all,
    input  logic              clear,
    input  logic [DIST_W-1:0] din,
    output logic [SUM_W-1:0]  next_sum,
    output logic [2:0]        fill
);
    logic [DIST_W-1:0] win [WIN_DEPTH];
    logic [SUM_W-1:0]  sum;

    // Empty slots hold zero, so the same update is valid while filling.
    assign next_sum = sum + SUM_W'(din) - SUM_W'(win[WIN_DEPTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (clear) begin
            for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (load_all) begin
            for (int i = 0; i < WIN_DEPTH; i++) win[i] <= din;
            sum  <= {din, 2'b00};
            fill <= 3'(WIN_DEPTH);
        end else if (load_one) begin
            win[0] <= din;
            for (int i = 1; i < WIN_DEPTH; i++) win[i] <= win[i-1];
            sum  <= next_sum;
            fill <= (fill == 3'(WIN_DEPTH)) ? fill : fill + 3'd1;
        end
    end
endmodule

// File: rtl/distance_filter.sv
// distance_filter: range gate, outlier rejection and 4-sample averaging of echo counts
//   clk, rst_n      clock, async active-low reset
//   in_valid        strobe: in_distance/in_timeout carry a measurement
//   in_distance     raw echo-width count
//   in_timeout      echo never returned (sample rejected)
//   out_valid       strobe: out_distance updated
//   out_distance    filtered count, held between strobes
//   out_stale       STALE_LIMIT or more consecutive rejected samples
//   out_fill        samples in the window, 0..4
module distance_filter
    import distance_pkg::*;
#(
    parameter logic [DIST_W-1:0] MIN_VALID   = 21'd116,
    parameter logic [DIST_W-1:0] MAX_VALID   = 21'd23200,
    parameter logic [DIST_W-1:0] JUMP_LIMIT  = 21'd580,
    parameter logic [3:0]        STALE_LIMIT = 4'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DIST_W-1:0] in_distance,
    input  logic              in_timeout,
    output logic              out_valid,
    output logic [DIST_W-1:0] out_distance,
    output logic              out_stale,
    output logic [2:0]        out_fill
);
    logic              s1_v;
    logic [DIST_W-1:0] s1_d;
    logic              s1_to;
    state_t            state;
    logic [1:0]        outl_cnt;
    logic [3:0]        rej_cnt;
    logic [DIST_W-1:0] avg_d;
    logic              emit_v;
    logic              in_range;
    logic              outlier;
    logic              load_one;
    logic              load_all;
    logic [SUM_W-1:0]  next_sum;

    // avg_d is the value the next out_distance will take; comparing against it
    // rather than out_distance keeps back-to-back samples consistent.
    always_comb begin
        in_range = s1_v && !s1_to && s1_d >= MIN_VALID && s1_d <= MAX_VALID;
        outlier  = state != ST_FILL && abs_diff(s1_d, avg_d) > JUMP_LIMIT;
        load_one = in_range && !outlier;
        load_all = in_range && outlier && outl_cnt == 2'd2;
    end

    dist_window u_win (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_one (load_one),
        .load_all (load_all),
        .clear    (1'b0),
        .din      (s1_d),
        .next_sum (next_sum),
        .fill     (out_fill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v         <= 1'b0;
            s1_d         <= '0;
            s1_to        <= 1'b0;
            state        <= ST_FILL;
            outl_cnt     <= '0;
            rej_cnt      <= '0;
            avg_d        <= '0;
            emit_v       <= 1'b0;
            out_valid    <= 1'b0;
            out_distance <= '0;
        end else begin
            s1_v      <= in_valid;
            s1_d      <= in_distance;
            s1_to     <= in_timeout;
            emit_v    <= load_one || load_all;
            out_valid <= emit_v;
            if (emit_v) out_distance <= avg_d;
            if (s1_v && !in_range) rej_cnt <= (rej_cnt == 4'd15) ? rej_cnt : rej_cnt + 4'd1;
            if (load_one || load_all) begin
                rej_cnt  <= '0;
                outl_cnt <= '0;
                avg_d    <= (load_all || state == ST_FILL) ? s1_d : next_sum[SUM_W-1:2];
                state    <= (state == ST_FILL && out_fill < 3'd3) ? ST_FILL : ST_TRACK;
            end else if (in_range) begin
                outl_cnt <= outl_cnt + 2'd1;
                state    <= ST_SUSPECT;
            end
        end
    end

    assign out_stale = rej_cnt >= STALE_LIMIT;
endmodule
